// File: rtl/gpio_port.sv
// gpio_port: parametrised GPIO block on the minx CPU register bus.
//
// Each pin has an input synchroniser, a debounce filter and rising/falling
// edge detection that feeds a write-1-to-clear pending register. The pending
// bits are OR-reduced into a registered, level-sensitive irq.
//
// Register map (offset from BASE_ADDR):
//   +0 DIR      1 = pin is an output
//   +1 DATA     write: output latch; read: latch on outputs, debounced input on inputs
//   +2 RISE_EN  rising-edge interrupt enable
//   +3 FALL_EN  falling-edge interrupt enable
//   +4 PEND     pending edges, write 1 to clear
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   clk_ce              clock enable for everything except the synchroniser
//   bus_write/bus_read  CPU strobes (reads are combinational, bus_read unused)
//   bus_address_in      24-bit register address
//   bus_data_in/out     write data / read data (0 when not addressed)
//   pin_in              raw asynchronous pad inputs
//   pin_out, pin_oe     output data and output enable to the pads
//   irq                 level interrupt request

// ---------------------------------------------------------------------------
// gpio_pin: one pin's input path (synchroniser, debounce, edge detect, pend).
// ---------------------------------------------------------------------------
module gpio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_ce,
    input  logic pin_in,
    input  logic dir,
    input  logic rise_en,
    input  logic fall_en,
    input  logic w1c,
    output logic deb,
    output logic pend
);
    logic [SYNC_STAGES-1:0] sync_pipe;
    logic                   sync_q;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;

    // Synchroniser runs every clk so metastability settling does not depend
    // on how often clk_ce fires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], pin_in};
    end

    assign sync_q = sync_pipe[SYNC_STAGES-1];

    generate
        if (DEBOUNCE == 0) begin : g_bypass
            assign deb = sync_q;
        end else begin : g_deb
            logic [7:0] cnt_q;
            logic       deb_q;

            // Counter measures how many consecutive ticks the synchronised
            // input has disagreed with the debounced value. The DEBOUNCE-th
            // consecutive disagreeing tick accepts the new level.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else if (clk_ce) begin
                    if (sync_q == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == 8'(DEBOUNCE - 1)) begin
                        deb_q <= sync_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            end

            assign deb = deb_q;
        end
    endgenerate

    // prev tracks deb on every tick regardless of direction, so turning an
    // output back into an input never produces a stale edge.
    assign rise = deb & ~prev_q & ~dir;
    assign fall = ~deb & prev_q & ~dir;

    // An edge on the same tick as a W1C of this bit keeps the bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
            pend   <= 1'b0;
        end else if (clk_ce) begin
            prev_q <= deb;
            pend   <= (pend & ~w1c) | (rise & rise_en) | (fall & fall_en);
        end
    end
endmodule

// ---------------------------------------------------------------------------
// gpio_port: register file, bus decode and the pin array.
// ---------------------------------------------------------------------------
module gpio_port #(
    parameter int          PINS        = 8,
    parameter logic [23:0] BASE_ADDR   = 24'h2060,
    parameter int          SYNC_STAGES = 2,
    parameter int          DEBOUNCE    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_ce,
    input  logic            bus_write,
    input  logic            bus_read,
    input  logic [23:0]     bus_address_in,
    input  logic [7:0]      bus_data_in,
    output logic [7:0]      bus_data_out,
    input  logic [PINS-1:0] pin_in,
    output logic [PINS-1:0] pin_out,
    output logic [PINS-1:0] pin_oe,
    output logic            irq
);
    localparam logic [2:0] OFF_DIR  = 3'd0;
    localparam logic [2:0] OFF_DATA = 3'd1;
    localparam logic [2:0] OFF_REN  = 3'd2;
    localparam logic [2:0] OFF_FEN  = 3'd3;
    localparam logic [2:0] OFF_PEND = 3'd4;

    typedef struct packed {
        logic       hit;   // address within BASE_ADDR..BASE_ADDR+4
        logic       wr;    // qualified write: hit, strobe and clock enable
        logic [2:0] off;   // register offset
        logic [7:0] data;
    } bus_req_t;

    bus_req_t        req;
    logic [23:0]     off_full;
    logic [PINS-1:0] dir_q;
    logic [PINS-1:0] data_q;
    logic [PINS-1:0] ren_q;
    logic [PINS-1:0] fen_q;
    logic [PINS-1:0] w1c;
    logic [PINS-1:0] deb;
    logic [PINS-1:0] pend;
    logic [PINS-1:0] rd_val;
    logic            irq_q;
    logic            unused_bits;

    // Unsigned subtraction wraps addresses below BASE_ADDR to large values,
    // so a single compare covers both ends of the window.
    assign off_full = bus_address_in - BASE_ADDR;
    assign req.hit  = off_full < 24'd5;
    assign req.off  = off_full[2:0];
    assign req.wr   = clk_ce & bus_write & req.hit;
    assign req.data = bus_data_in;

    // Reads are combinational, so the read strobe and the write-data bits
    // above PINS have no function here.
    assign unused_bits = &{1'b0, bus_read, req};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir_q  <= '0;
            data_q <= '0;
            ren_q  <= '0;
            fen_q  <= '0;
        end else if (req.wr) begin
            case (req.off)
                OFF_DIR:  dir_q  <= req.data[PINS-1:0];
                OFF_DATA: data_q <= req.data[PINS-1:0];
                OFF_REN:  ren_q  <= req.data[PINS-1:0];
                OFF_FEN:  fen_q  <= req.data[PINS-1:0];
                default:  ;
            endcase
        end
    end

    assign w1c = (req.wr && req.off == OFF_PEND) ? req.data[PINS-1:0] : '0;

    gpio_pin #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEBOUNCE    (DEBOUNCE)
    ) u_pin [PINS-1:0] (
        .clk     (clk),
        .reset   (reset),
        .clk_ce  (clk_ce),
        .pin_in  (pin_in),
        .dir     (dir_q),
        .rise_en (ren_q),
        .fall_en (fen_q),
        .w1c     (w1c),
        .deb     (deb),
        .pend    (pend)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      irq_q <= 1'b0;
        else if (clk_ce) irq_q <= |pend;
    end

    always_comb begin
        rd_val = '0;
        case (req.off)
            OFF_DIR:  rd_val = dir_q;
            OFF_DATA: rd_val = (dir_q & data_q) | (~dir_q & deb);
            OFF_REN:  rd_val = ren_q;
            OFF_FEN:  rd_val = fen_q;
            OFF_PEND: rd_val = pend;
            default:  rd_val = '0;
        endcase
        bus_data_out = '0;
        if (req.hit) bus_data_out[PINS-1:0] = rd_val;
    end

    assign pin_out = data_q;
    assign pin_oe  = dir_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: directed and randomised checks of gpio_port against a
// behavioural model. The model filters each pin with a window of the last
// DEB clock-enable samples of the synchronised input and applies the
// register rules directly.
module tb_gpio_port;
    localparam logic [23:0] BASE  = 24'h2060;
    localparam logic [23:0] BASE3 = 24'h2070;
    localparam int          SYNC  = 2;
    localparam int          DEB   = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_ce = 1'b1;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [23:0] bus_address_in = BASE;
    logic [7:0]  bus_data_in = 8'h00;
    logic [7:0]  bus_data_out;
    logic [7:0]  pin_in = 8'h00;
    logic [7:0]  pin_out;
    logic [7:0]  pin_oe;
    logic        irq;
    logic [7:0]  rdata3;
    logic [2:0]  pin_in3 = 3'b000;
    logic [2:0]  pin_out3;
    logic [2:0]  pin_oe3;
    logic        irq3;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    gpio_port dut (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write),
        .bus_read(bus_read), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
    );

    gpio_port #(.PINS(3), .BASE_ADDR(BASE3)) dut3 (
        .clk(clk), .reset(reset), .clk_ce(clk_ce), .bus_write(bus_write),
        .bus_read(bus_read), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(rdata3),
        .pin_in(pin_in3), .pin_out(pin_out3), .pin_oe(pin_oe3), .irq(irq3)
    );

    // ---------------- reference model ----------------
    logic [7:0] m_dir, m_data, m_ren, m_fen, m_pend, m_deb, m_prev;
    logic       m_irq;
    logic [7:0] m_sync[$];   // raw pin samples still inside the synchroniser
    logic [7:0] m_hist[$];   // synchronised values seen on the last DEB ticks

    function automatic void m_reset();
        m_dir = 0; m_data = 0; m_ren = 0; m_fen = 0;
        m_pend = 0; m_deb = 0; m_prev = 0; m_irq = 1'b0;
        m_sync = {};
        m_hist = {};
        for (int i = 0; i < SYNC; i++) m_sync.push_back(8'h00);
        for (int i = 0; i < DEB; i++)  m_hist.push_back(8'h00);
    endfunction

    function automatic logic [7:0] m_read(input logic [23:0] a);
        int o;
        o = int'(a) - int'(BASE);
        case (o)
            0: return m_dir;
            1: return (m_dir & m_data) | (~m_dir & m_deb);
            2: return m_ren;
            3: return m_fen;
            4: return m_pend;
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_step();
        logic [7:0] s, rise, fall, w1c, all1, any1;
        int o;
        s = m_sync.pop_front();
        m_sync.push_back(pin_in);
        if (!clk_ce) return;
        o    = int'(bus_address_in) - int'(BASE);
        rise = m_deb & ~m_prev & ~m_dir;
        fall = ~m_deb & m_prev & ~m_dir;
        w1c  = (bus_write && o == 4) ? bus_data_in : 8'h00;
        m_irq  = |m_pend;
        m_pend = (m_pend & ~w1c) | (rise & m_ren) | (fall & m_fen);
        m_prev = m_deb;
        // A pin accepts a new level once the last DEB samples all disagree.
        m_hist.push_back(s);
        void'(m_hist.pop_front());
        all1 = 8'hFF;
        any1 = 8'h00;
        foreach (m_hist[i]) begin
            all1 &= m_hist[i];
            any1 |= m_hist[i];
        end
        m_deb = m_deb ^ ((~m_deb & all1) | (m_deb & ~any1));
        if (bus_write) begin
            case (o)
                0: m_dir  = bus_data_in;
                1: m_data = bus_data_in;
                2: m_ren  = bus_data_in;
                3: m_fen  = bus_data_in;
                default: ;
            endcase
        end
    endfunction

    always @(posedge clk) if (reset) m_step();
    always @(negedge reset) m_reset();

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
    endtask

    task automatic chk_outs();
        chk("irq", {7'b0, irq}, {7'b0, m_irq});
        chk("pin_oe", pin_oe, m_dir);
        chk("pin_out", pin_out, m_data);
    endtask

    // One clock: drive the bus after a negedge, return at the next negedge.
    task automatic cyc(input logic wr, input logic [23:0] a, input logic [7:0] d);
        bus_write = wr; bus_address_in = a; bus_data_in = d; bus_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_write = 1'b0;
        chk_outs();
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        cyc(1'b1, a, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, BASE + 24'd5, 8'h00);
    endtask

    // Combinational read without advancing the clock.
    task automatic peek(input logic [23:0] a, input string tag);
        bus_address_in = a; bus_read = 1'b1;
        #1;
        chk(tag, bus_data_out, m_read(a));
        bus_read = 1'b0;
    endtask

    function automatic logic [23:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 7));
        if (r <= 5) return BASE + 24'(r);
        if (r == 6) return BASE - 24'd1;
        return BASE3;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        peek(BASE, "rst_dir_in_reset");
        chk("rst_irq", {7'b0, irq}, 8'h00);
        chk("rst_oe", pin_oe, 8'h00);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            peek(BASE + 24'(i), "rst_readback");
            chk("rst_readback_zero", bus_data_out, 8'h00);
        end

        // Direction and output data.
        wr(BASE + 0, 8'hF0);
        wr(BASE + 1, 8'hA5);
        chk("oe_f0", pin_oe, 8'hF0);
        chk("out_a5", pin_out, 8'hA5);
        pin_in = 8'h0C;
        idle(6);
        peek(BASE + 1, "data_ac");
        chk("data_ac_const", bus_data_out, 8'hAC);

        // Debounce: short glitch rejected, held level accepted after 2+4.
        wr(BASE + 2, 8'h01);
        wr(BASE + 3, 8'h02);
        pin_in = 8'h0D;
        idle(3);
        pin_in = 8'h0C;
        idle(8);
        peek(BASE + 1, "glitch_data");
        chk("glitch_data_const", bus_data_out, 8'hAC);
        peek(BASE + 4, "glitch_pend");
        chk("glitch_pend_const", bus_data_out, 8'h00);
        pin_in = 8'h0D;
        idle(5);
        peek(BASE + 1, "deb_at5");
        chk("deb_at5_const", bus_data_out, 8'hAC);
        idle(1);
        peek(BASE + 1, "deb_at6");
        chk("deb_at6_const", bus_data_out, 8'hAD);
        idle(1);
        peek(BASE + 4, "rise_pend");
        chk("rise_pend_const", bus_data_out, 8'h01);
        idle(1);
        chk("rise_irq_const", {7'b0, irq}, 8'h01);

        // pin1 up then down: only the falling edge is enabled.
        pin_in = 8'h0F;
        idle(8);
        pin_in = 8'h0D;
        idle(8);
        peek(BASE + 4, "fall_pend");
        chk("fall_pend_const", bus_data_out, 8'h03);
        wr(BASE + 4, 8'h01);
        peek(BASE + 4, "w1c_bit0");
        chk("w1c_bit0_const", bus_data_out, 8'h02);
        idle(1);
        chk("irq_still_set", {7'b0, irq}, 8'h01);
        wr(BASE + 4, 8'h02);
        idle(1);
        chk("irq_cleared", {7'b0, irq}, 8'h00);

        // Rising edge and W1C of the same bit on the same tick: set wins.
        wr(BASE + 3, 8'h03);
        pin_in = 8'h0C;
        idle(8);
        peek(BASE + 4, "sim_pre");
        chk("sim_pre_const", bus_data_out, 8'h01);
        pin_in = 8'h0D;
        idle(6);
        wr(BASE + 4, 8'h01);
        peek(BASE + 4, "sim_set_wins");
        chk("sim_set_wins_const", bus_data_out, 8'h01);
        wr(BASE + 4, 8'h01);
        wr(BASE + 3, 8'h02);

        // clk_ce low freezes everything but the synchroniser.
        clk_ce = 1'b0;
        wr(BASE + 1, 8'h5A);
        wr(BASE + 0, 8'h0F);
        pin_in = 8'h00;
        idle(8);
        chk("ce_hold_out", pin_out, 8'hA5);
        peek(BASE + 1, "ce_hold_data");
        clk_ce = 1'b1;
        idle(8);
        peek(BASE + 1, "ce_resume_data");

        // Second instance: PINS=3 at a relocated base.
        wr(BASE3, 8'hFF);
        bus_address_in = BASE3; #1;
        chk("p3_dir", rdata3, 8'h07);
        chk("p3_oe", {5'b0, pin_oe3}, 8'h07);
        peek(BASE, "p3_main_dir");
        chk("p3_foreign_rd", rdata3, 8'h00);
        wr(BASE, 8'hF0);
        bus_address_in = BASE3; #1;
        chk("p3_dir_kept", rdata3, 8'h07);
        peek(BASE3, "main_foreign_rd");

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) pin_in = pin_in ^ 8'(1 << $urandom_range(0, 7));
            clk_ce = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) cyc(1'b1, pick_addr(), 8'($urandom));
            else                           cyc(1'b0, pick_addr(), 8'h00);
            peek(pick_addr(), "rnd_rd");
        end
        clk_ce = 1'b1;

        // Asynchronous reset pulse with pending bits and running counters.
        wr(BASE + 0, 8'h00);
        wr(BASE + 2, 8'hFF);
        wr(BASE + 3, 8'hFF);
        wr(BASE + 4, 8'hFF);
        pin_in = 8'h00;
        idle(10);
        wr(BASE + 4, 8'hFF);
        pin_in = 8'h55;
        idle(10);
        peek(BASE + 4, "pre_rst_pend");
        chk("pre_rst_pend_const", bus_data_out, 8'h55);
        pin_in = 8'hAA;
        idle(3);
        #1 reset = 1'b0; bus_address_in = BASE + 4;
        #1;
        chk("arst_pend", bus_data_out, 8'h00);
        chk("arst_irq", {7'b0, irq}, 8'h00);
        chk("arst_oe", pin_oe, 8'h00);
        chk("arst_out", pin_out, 8'h00);
        #1 reset = 1'b1;
        idle(20);
        peek(BASE + 4, "post_rst_pend");
        chk("post_rst_pend_const", bus_data_out, 8'h00);
        chk("post_rst_irq", {7'b0, irq}, 8'h00);
        peek(BASE + 1, "post_rst_data");
        wr(BASE + 0, 8'h3C);
        chk("post_rst_dir", pin_oe, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
